program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Byte-stream program loader for the MC14500B core: the writer side of the
//  core's program-store write port. Receives a framed byte stream
//  (valid/ready), packs bytes into WORD-bit commands and writes them to
//  consecutive program addresses. Holds the core in reset until a frame
//  passes its checksum.
// PARAMETERS
//  ADDR  8         program address width; 1..8 (length field is one byte)
//  CODE  4         opcode width
//  WORD  ADDR+CODE command width; BPW = ceil(WORD/8) bytes per word (12 -> 2)
//  HDR   8'hA5     frame header byte
// PORTS
//  clk         in   1     system clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  in_valid    in   1     byte available on in_data
//  in_data     in   8     stream byte
//  in_ready    out  1     loader accepts in_data this cycle
//  prog_write  out  1     one-cycle program-store write strobe
//  prog_addr   out  ADDR  write address; valid while prog_write=1
//  prog_cmd    out  WORD  write data; valid while prog_write=1
//  core_hold   out  1     1 = keep core in reset (drives core reset)
//  load_done   out  1     last frame loaded and checksum good (sticky)
//  load_err    out  1     last frame failed (sticky until next header)
// BEHAVIOUR
//  Byte transfer only when in_valid & in_ready, sampled on rising clk.
//  Reset (rst=0, async): state=IDLE, in_ready=0 while in reset, prog_write=0,
//   prog_addr=0, prog_cmd=0, core_hold=1, load_done=0, load_err=0.
//  Frame: HDR, LEN, LEN x BPW payload bytes (MSB byte first), CHK.
//   LEN = word count; 0 encodes 256. CHK = XOR of all payload bytes only.
//   Unused high bits of each word's first byte are ignored.
//  States:
//   IDLE  in_ready=1. Byte==HDR -> LEN: core_hold=1, load_done=0,
//         load_err=0, idx=0, chk=0. Other bytes dropped, flags unchanged.
//   LEN   in_ready=1. Store count; if count > 2**ADDR -> IDLE with
//         load_err=1 (no writes); else -> DATA, byte counter=0.
//   DATA  in_ready=1. Shift byte into word register, XOR into chk. After
//         byte BPW-1 of a word -> WRITE.
//   WRITE in_ready=0 for exactly one cycle. prog_write=1,
//         prog_addr=idx, prog_cmd=word. idx+1; if idx was count-1 -> CHK,
//         else -> DATA.
//   CHK   in_ready=1. Byte==chk -> IDLE with load_done=1, core_hold=0.
//         Mismatch -> IDLE with load_err=1, core_hold stays 1 (already
//         written words stay in the store; next frame overwrites them).
//  Latency: last byte of a word accepted at cycle t -> prog_write at t+1.
//  idx is ADDR bits wide; for 256 words at ADDR=8 last address is 255,
//   terminal test uses the count, not idx wrap.
//  HDR value inside LEN/DATA/CHK is ordinary data (no resync mid-frame).
//  in_valid gaps: state holds; no timeout.
//  Reset mid-frame: partial frame discarded, outputs to reset values,
//   core held.
//  prog_write never asserted outside WRITE; never two in consecutive
//   cycles.
// TESTING
//  1 Reset, send A5 02 01 23 0A BC 94 -> writes (0,0x123),(1,0xABC),
//    load_done=1, core_hold=0, load_err=0.
//  2 Same frame with CHK=0x95 -> both writes occur, load_err=1,
//    load_done=0, core_hold=1.
//  3 Bytes 00 FF 3C then frame 1 -> leading bytes ignored, result as in
//    scenario 1.
//  4 Frame 1 with in_valid toggled randomly every cycle -> identical
//    writes/flags; in_ready=0 only in the cycle after a word completes.
//  5 LEN=00, 256 words value=address -> 256 writes, addresses 0..255,
//    load_done=1.
//  6 rst low after 3rd payload byte of frame 1 -> one write seen, then all
//    outputs at reset values; fresh frame 1 loads correctly.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Byte-stream program loader for the MC14500B core. Accepts a
//                framed valid/ready byte stream (HDR, LEN, payload, CHK),
//                packs payload bytes MSB-first into WORD-bit commands, writes
//                them to consecutive program addresses and holds the core in
//                reset until a frame passes its XOR checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int         ADDR = 8,
    parameter int         CODE = 4,
    parameter int         WORD = ADDR + CODE,
    parameter logic [7:0] HDR  = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            prog_write,
    output logic [ADDR-1:0] prog_addr,
    output logic [WORD-1:0] prog_cmd,
    output logic            core_hold,
    output logic            load_done,
    output logic            load_err
);

    // Bytes per command word and the largest word count the address space holds.
    localparam int         BPW       = (WORD + 7) / 8;
    localparam logic [7:0] LAST_BYTE = 8'(BPW - 1);
    localparam logic [8:0] MAX_WORDS = 9'(1 << ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4
    } state_t;

    state_t          state;
    logic [8:0]      count;      // words in this frame, 1..256
    logic [ADDR-1:0] idx;        // next program address
    logic [7:0]      chk;        // running XOR of payload bytes
    logic [7:0]      bcnt;       // byte position inside current word
    logic [WORD-1:0] shreg;      // word being assembled

    logic            accept;
    logic [8:0]      len_count;
    logic [WORD-1:0] next_word;
    logic            last_word;

    // Handshake, LEN decode (0 means 256), byte shift with high bits of the
    // first byte falling off the top, and terminal test on count not idx wrap.
    always_comb begin
        accept    = in_valid & in_ready;
        len_count = {(in_data == 8'h00), in_data};
        next_word = WORD'({shreg, in_data});
        last_word = ((9'(idx) + 9'd1) == count);
    end

    // Frame parser with registered handshake, write port and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            prog_write <= 1'b0;
            prog_addr  <= '0;
            prog_cmd   <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            count      <= '0;
            idx        <= '0;
            chk        <= '0;
            bcnt       <= '0;
            shreg      <= '0;
        end else begin
            in_ready   <= 1'b1;
            prog_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && in_data == HDR) begin
                        core_hold <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        idx       <= '0;
                        chk       <= '0;
                        state     <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        count <= len_count;
                        if (len_count > MAX_WORDS) begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            bcnt  <= '0;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shreg <= next_word;
                        chk   <= chk ^ in_data;
                        if (bcnt == LAST_BYTE) begin
                            // Word complete: present it on the write port now
                            // and close the input for the single WRITE cycle.
                            bcnt       <= '0;
                            prog_write <= 1'b1;
                            prog_addr  <= idx;
                            prog_cmd   <= next_word;
                            in_ready   <= 1'b0;
                            state      <= S_WRITE;
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                end
                S_WRITE: begin
                    idx   <= idx + 1'b1;
                    state <= last_word ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    if (accept) begin
                        if (in_data == chk) begin
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Directed self-checking bench for program_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        prog_write;
    logic [7:0]  prog_addr;
    logic [11:0] prog_cmd;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int vec;
    int err;

    // Captured program-store writes and protocol monitors.
    logic [7:0]  wa_q[$];
    logic [11:0] wc_q[$];
    logic        prev_pw;
    int          dbl_writes;
    int          rdy_bad;
    logic        mon_on;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .prog_write (prog_write),
        .prog_addr  (prog_addr),
        .prog_cmd   (prog_cmd),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record writes and watch for back-to-back strobes / stray ready drops.
    always @(negedge clk) begin
        if (prog_write === 1'b1) begin
            wa_q.push_back(prog_addr);
            wc_q.push_back(prog_cmd);
            if (prev_pw === 1'b1) dbl_writes++;
        end
        if (mon_on && (in_ready !== ~prog_write)) rdy_bad++;
        prev_pw = prog_write;
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int n;
        if (maxgap > 0) begin
            n = $urandom_range(maxgap, 0);
            repeat (n) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vec++; err++;
            $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] chkb, input int maxgap);
        send_byte(8'hA5, maxgap);
        send_byte(8'h02, maxgap);
        send_byte(8'h01, maxgap);
        send_byte(8'h23, maxgap);
        send_byte(8'h0A, maxgap);
        send_byte(8'hBC, maxgap);
        send_byte(chkb,  maxgap);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++; if (in_ready !== 1'b0)     begin err++; $display("FAIL rst_ready got %b exp 0", in_ready); end
        vec++; if (prog_write !== 1'b0)   begin err++; $display("FAIL rst_write got %b exp 0", prog_write); end
        vec++; if (prog_addr !== 8'h00)   begin err++; $display("FAIL rst_addr got %h exp 00", prog_addr); end
        vec++; if (prog_cmd !== 12'h000)  begin err++; $display("FAIL rst_cmd got %h exp 000", prog_cmd); end
        vec++; if (core_hold !== 1'b1)    begin err++; $display("FAIL rst_hold got %b exp 1", core_hold); end
        vec++; if (load_done !== 1'b0)    begin err++; $display("FAIL rst_done got %b exp 0", load_done); end
        vec++; if (load_err !== 1'b0)     begin err++; $display("FAIL rst_err got %b exp 0", load_err); end
        rst = 1'b1;
    endtask

    task automatic test_frame_ok();
        int base = wa_q.size();
        send_frame1(8'h94, 0);
        vec++; if (wa_q.size() - base !== 2) begin err++; $display("FAIL ok_nwrites got %0d exp 2", wa_q.size() - base); end
        else begin
            vec++; if (wa_q[base] !== 8'd0 || wc_q[base] !== 12'h123) begin err++; $display("FAIL ok_w0 got %h/%h exp 00/123", wa_q[base], wc_q[base]); end
            vec++; if (wa_q[base+1] !== 8'd1 || wc_q[base+1] !== 12'hABC) begin err++; $display("FAIL ok_w1 got %h/%h exp 01/abc", wa_q[base+1], wc_q[base+1]); end
        end
        vec++; if (load_done !== 1'b1) begin err++; $display("FAIL ok_done got %b exp 1", load_done); end
        vec++; if (core_hold !== 1'b0) begin err++; $display("FAIL ok_hold got %b exp 0", core_hold); end
        vec++; if (load_err !== 1'b0)  begin err++; $display("FAIL ok_err got %b exp 0", load_err); end
    endtask

    task automatic test_bad_chk();
        int base = wa_q.size();
        send_frame1(8'h95, 0);
        vec++; if (wa_q.size() - base !== 2) begin err++; $display("FAIL bad_nwrites got %0d exp 2", wa_q.size() - base); end
        else begin
            vec++; if (wc_q[base] !== 12'h123 || wc_q[base+1] !== 12'hABC) begin err++; $display("FAIL bad_data got %h/%h exp 123/abc", wc_q[base], wc_q[base+1]); end
        end
        vec++; if (load_err !== 1'b1)  begin err++; $display("FAIL bad_err got %b exp 1", load_err); end
        vec++; if (load_done !== 1'b0) begin err++; $display("FAIL bad_done got %b exp 0", load_done); end
        vec++; if (core_hold !== 1'b1) begin err++; $display("FAIL bad_hold got %b exp 1", core_hold); end
    endtask

    task automatic test_leading_junk();
        int base = wa_q.size();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h3C, 0);
        @(negedge clk);
        vec++; if (load_err !== 1'b1) begin err++; $display("FAIL junk_flags_kept got %b exp 1", load_err); end
        send_frame1(8'h94, 0);
        vec++; if (wa_q.size() - base !== 2) begin err++; $display("FAIL junk_nwrites got %0d exp 2", wa_q.size() - base); end
        else begin
            vec++; if (wa_q[base+1] !== 8'd1 || wc_q[base+1] !== 12'hABC) begin err++; $display("FAIL junk_w1 got %h/%h exp 01/abc", wa_q[base+1], wc_q[base+1]); end
        end
        vec++; if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0) begin
            err++; $display("FAIL junk_flags got done=%b hold=%b err=%b exp 1/0/0", load_done, core_hold, load_err); end
    endtask

    task automatic test_valid_gaps();
        int base = wa_q.size();
        rdy_bad = 0;
        mon_on  = 1'b1;
        send_frame1(8'h94, 3);
        mon_on  = 1'b0;
        vec++; if (wa_q.size() - base !== 2) begin err++; $display("FAIL gap_nwrites got %0d exp 2", wa_q.size() - base); end
        else begin
            vec++; if (wc_q[base] !== 12'h123 || wc_q[base+1] !== 12'hABC) begin err++; $display("FAIL gap_data got %h/%h exp 123/abc", wc_q[base], wc_q[base+1]); end
        end
        vec++; if (rdy_bad !== 0) begin err++; $display("FAIL gap_ready got %0d bad cycles exp 0", rdy_bad); end
        vec++; if (load_done !== 1'b1 || core_hold !== 1'b0) begin err++; $display("FAIL gap_flags got done=%b hold=%b exp 1/0", load_done, core_hold); end
    endtask

    task automatic test_256_words();
        int base = wa_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00, 0);
            send_byte(8'(i), 0);
        end
        // XOR of 0..255 is zero.
        send_byte(8'h00, 0);
        @(negedge clk);
        vec++; if (wa_q.size() - base !== 256) begin err++; $display("FAIL w256_nwrites got %0d exp 256", wa_q.size() - base); end
        else begin
            for (int i = 0; i < 256; i++) begin
                vec++;
                if (wa_q[base+i] !== 8'(i) || wc_q[base+i] !== 12'(i)) begin
                    err++; $display("FAIL w256_entry%0d got %h/%h exp %h/%h", i, wa_q[base+i], wc_q[base+i], 8'(i), 12'(i));
                end
            end
        end
        vec++; if (load_done !== 1'b1 || load_err !== 1'b0 || core_hold !== 1'b0) begin
            err++; $display("FAIL w256_flags got done=%b err=%b hold=%b exp 1/0/0", load_done, load_err, core_hold); end
    endtask

    task automatic test_reset_mid();
        int base = wa_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h23, 0);
        send_byte(8'h0A, 0);
        @(negedge clk);
        vec++; if (wa_q.size() - base !== 1) begin err++; $display("FAIL mid_nwrites got %0d exp 1", wa_q.size() - base); end
        rst = 1'b0;
        #1;
        vec++; if (in_ready !== 1'b0 || prog_write !== 1'b0 || prog_addr !== 8'h00 || prog_cmd !== 12'h000) begin
            err++; $display("FAIL mid_port got rdy=%b wr=%b addr=%h cmd=%h exp 0/0/00/000", in_ready, prog_write, prog_addr, prog_cmd); end
        vec++; if (core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
            err++; $display("FAIL mid_flags got hold=%b done=%b err=%b exp 1/0/0", core_hold, load_done, load_err); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        base = wa_q.size();
        send_frame1(8'h94, 0);
        vec++; if (wa_q.size() - base !== 2) begin err++; $display("FAIL mid_reload_n got %0d exp 2", wa_q.size() - base); end
        else begin
            vec++; if (wa_q[base] !== 8'd0 || wc_q[base] !== 12'h123 || wc_q[base+1] !== 12'hABC) begin
                err++; $display("FAIL mid_reload_data got %h/%h/%h exp 00/123/abc", wa_q[base], wc_q[base], wc_q[base+1]); end
        end
        vec++; if (load_done !== 1'b1 || core_hold !== 1'b0) begin err++; $display("FAIL mid_reload_flags got done=%b hold=%b exp 1/0", load_done, core_hold); end
    endtask

    task automatic test_back_to_back();
        vec++; if (dbl_writes !== 0) begin err++; $display("FAIL consecutive_writes got %0d exp 0", dbl_writes); end
    endtask

    initial begin
        vec = 0; err = 0;
        dbl_writes = 0; rdy_bad = 0; mon_on = 1'b0; prev_pw = 1'b0;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_frame_ok();
        test_bad_chk();
        test_leading_junk();
        test_valid_gaps();
        test_256_words();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
`default_nettype wire
